level_shifter_up_seq: RTL and testbench

LEVEL_SHIFTER_UP_SEQ -- requirements
Module: level_shifter_up_seq

---
 rtl/level_shifter_up_seq.sv | 142 ++++++++++++++
 tb/tb_level_shifter_up_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/level_shifter_up_seq.sv
// ---------------------------------------------------------------------------
// level_shifter_up_seq
//
// Purpose:
//   Sequences the enable of a bank of low-V -> high-V up-shifters. The low
//   supply power-good is synchronized into the high-V clock domain and must
//   stay good for SETTLE_CYCLES consecutive cycles before the shifters are
//   enabled. While not enabled, data_out is clamped to CLAMP_VAL so the
//   high-V domain never sees floating or stale low-V data.
//
// Optional feature (macro LS_UP_FAULT_CNT_EN):
//   Defined   : fault_cnt counts ACTIVE->ISOLATED exits caused by loss of
//               the low supply, saturating at 255, cleared only by rst.
//   Undefined : fault_cnt is tied to 0 and no counter is built.
//
// Ports:
//   clk           in   high-V domain clock, rising edge
//   rst           in   asynchronous active-high reset
//   low_pwr_good  in   low-V supply power-good (asynchronous to clk)
//   iso_req       in   isolation request, synchronous to clk (1 = isolate)
//   data_in       in   [WIDTH-1:0] data from the low-V domain
//   data_out      out  [WIDTH-1:0] registered level-shifted data
//   shifter_en    out  1 while in ACTIVE
//   iso_active    out  1 while in ISOLATED or SETTLE
//   fault_cnt     out  [7:0] power-loss drop counter
// ---------------------------------------------------------------------------
module level_shifter_up_seq #(
  parameter int               WIDTH         = 8,
  parameter int               SETTLE_CYCLES = 16,
  parameter logic [WIDTH-1:0] CLAMP_VAL     = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             low_pwr_good,
  input  logic             iso_req,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             shifter_en,
  output logic             iso_active,
  output logic [7:0]       fault_cnt
);

  localparam int             CNT_W    = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_ISOLATED = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_ACTIVE   = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       sync_q;
  logic [WIDTH-1:0] data_q;

  logic pgood_s;
  logic leave_d;

  // Only the second synchronizer stage is ever looked at by the FSM.
  assign pgood_s = sync_q[1];

  // Any cycle with the supply bad or isolation requested forces ISOLATED.
  assign leave_d = !pgood_s || iso_req;

  // Sequencer: synchronizer, FSM, settle counter and the data register
  // share one process so data_out always follows the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      state_q <= ST_ISOLATED;
      cnt_q   <= '0;
      data_q  <= CLAMP_VAL;
    end else begin
      sync_q <= {sync_q[0], low_pwr_good};
      case (state_q)
        ST_ISOLATED: begin
          cnt_q  <= '0;
          data_q <= CLAMP_VAL;
          if (!leave_d) begin
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (leave_d) begin
            // No partial credit: a glitch restarts the whole settle window.
            state_q <= ST_ISOLATED;
            cnt_q   <= '0;
            data_q  <= CLAMP_VAL;
          end else if (cnt_q == CNT_LAST) begin
            // Entering ACTIVE: data_in is captured on this same edge.
            state_q <= ST_ACTIVE;
            cnt_q   <= '0;
            data_q  <= data_in;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            data_q <= CLAMP_VAL;
          end
        end
        ST_ACTIVE: begin
          if (leave_d) begin
            // Clamp lands on the same edge shifter_en falls.
            state_q <= ST_ISOLATED;
            data_q  <= CLAMP_VAL;
          end else begin
            data_q <= data_in;
          end
        end
        default: begin
          state_q <= ST_ISOLATED;
          cnt_q   <= '0;
          data_q  <= CLAMP_VAL;
        end
      endcase
    end
  end

  // Status decoded purely from the state register.
  assign shifter_en = (state_q == ST_ACTIVE);
  assign iso_active = !shifter_en;
  assign data_out   = data_q;

`ifdef LS_UP_FAULT_CNT_EN
  logic [7:0] fault_q;

  // ACTIVE with pgood_s low always exits to ISOLATED on this edge, so this
  // condition is exactly a power-loss drop (including a simultaneous
  // iso_req). Drops caused only by iso_req have pgood_s high and are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_q <= 8'd0;
    end else if ((state_q == ST_ACTIVE) && !pgood_s && (fault_q != 8'hFF)) begin
      fault_q <= fault_q + 8'd1;
    end
  end

  assign fault_cnt = fault_q;
`else
  assign fault_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_level_shifter_up_seq.sv
// ---------------------------------------------------------------------------
// tb_level_shifter_up_seq
//
// Directed bench for level_shifter_up_seq with WIDTH=8, SETTLE_CYCLES=4 and
// a non-zero CLAMP_VAL so clamped and passed data are distinguishable.
// Expected fault_cnt values follow LS_UP_FAULT_CNT_EN if it is defined.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_level_shifter_up_seq;

  localparam int         WIDTH  = 8;
  localparam int         SETTLE = 4;
  localparam logic [7:0] CLAMP  = 8'hC3;

`ifdef LS_UP_FAULT_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             low_pwr_good;
  logic             iso_req;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             shifter_en;
  logic             iso_active;
  logic [7:0]       fault_cnt;

  int n_checks = 0;
  int n_err    = 0;
  int exp_fc   = 0;

  level_shifter_up_seq #(
    .WIDTH         (WIDTH),
    .SETTLE_CYCLES (SETTLE),
    .CLAMP_VAL     (CLAMP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .low_pwr_good (low_pwr_good),
    .iso_req      (iso_req),
    .data_in      (data_in),
    .data_out     (data_out),
    .shifter_en   (shifter_en),
    .iso_active   (iso_active),
    .fault_cnt    (fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end else begin
      $display("check %s: got %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Bounded wait for ACTIVE; an expired budget shows up as a failed check.
  task automatic wait_active(input string tag);
    for (int i = 0; i < 20 && !shifter_en; i++) tick();
    check(tag, shifter_en, 1);
  endtask

  task automatic bump_fc();
    if (FC_EN && exp_fc < 255) exp_fc++;
  endtask

  initial begin
    rst          = 1'b1;
    low_pwr_good = 1'b0;
    iso_req      = 1'b0;
    data_in      = 8'h00;

    // Reset state
    #12;
    check("rst_shifter_en", shifter_en, 0);
    check("rst_iso_active", iso_active, 1);
    check("rst_data_out", data_out, CLAMP);
    check("rst_fault_cnt", fault_cnt, 0);

    // Power-up: supply good before edge 1, SETTLE at edge 3, ACTIVE at edge 7
    tick();
    rst          = 1'b0;
    low_pwr_good = 1'b1;
    data_in      = 8'h11;
    ticks(2);
    check("pu_e2_shifter_en", shifter_en, 0);
    ticks(4);
    check("pu_e6_shifter_en", shifter_en, 0);
    check("pu_e6_data_out", data_out, CLAMP);
    tick();
    check("pu_e7_shifter_en", shifter_en, 1);
    check("pu_e7_iso_active", iso_active, 0);
    check("pu_e7_data_out", data_out, 8'h11);

    // Data pass-through with one cycle of latency
    data_in = 8'hA5;
    tick();
    check("act_data_a5", data_out, 8'hA5);
    data_in = 8'h3C;
    tick();
    check("act_data_3c", data_out, 8'h3C);

    // iso_req alone: clamp on the next edge, no fault counted
    iso_req = 1'b1;
    tick();
    check("iso_shifter_en", shifter_en, 0);
    check("iso_data_out", data_out, CLAMP);
    check("iso_fault_cnt", fault_cnt, 0);
    data_in = 8'h77;
    tick();
    check("iso_hold_data_out", data_out, CLAMP);
    iso_req = 1'b0;
    ticks(4);
    check("iso_rel_e4_shifter_en", shifter_en, 0);
    tick();
    check("iso_rel_e5_shifter_en", shifter_en, 1);
    check("iso_rel_e5_data_out", data_out, 8'h77);

    // Simultaneous supply loss and iso_req on the exit edge counts as a fault
    low_pwr_good = 1'b0;
    ticks(2);
    check("both_e2_shifter_en", shifter_en, 1);
    iso_req = 1'b1;
    tick();
    bump_fc();
    check("both_shifter_en", shifter_en, 0);
    check("both_data_out", data_out, CLAMP);
    check("both_fault_cnt", fault_cnt, exp_fc);
    iso_req      = 1'b0;
    low_pwr_good = 1'b1;
    wait_active("both_recover");

    // Repeated power-loss drops from ACTIVE: saturation at 255
    for (int n = 1; n <= 257; n++) begin
      low_pwr_good = 1'b0;
      ticks(3);
      bump_fc();
      if (n == 1 || n == 253 || n == 254 || n == 257) begin
        check($sformatf("drop%0d_shifter_en", n), shifter_en, 0);
        check($sformatf("drop%0d_fault_cnt", n), fault_cnt, exp_fc);
      end
      low_pwr_good = 1'b1;
      wait_active($sformatf("drop%0d_recover", n));
    end

    // Asynchronous reset while ACTIVE, between edges
    data_in = 8'h5E;
    tick();
    rst = 1'b1;
    #2;
    check("arst_shifter_en", shifter_en, 0);
    check("arst_iso_active", iso_active, 1);
    check("arst_data_out", data_out, CLAMP);
    check("arst_fault_cnt", fault_cnt, 0);
    #3;
    rst = 1'b0;
    ticks(6);
    check("arst_e6_shifter_en", shifter_en, 0);
    tick();
    check("arst_e7_shifter_en", shifter_en, 1);
    check("arst_e7_data_out", data_out, 8'h5E);

    // One-cycle supply glitch mid-SETTLE restarts the full settle window
    tick();
    rst = 1'b1;
    #2;
    low_pwr_good = 1'b0;
    #2;
    rst          = 1'b0;
    low_pwr_good = 1'b1;
    ticks(3);
    low_pwr_good = 1'b0;
    tick();
    low_pwr_good = 1'b1;
    ticks(2);
    check("gl_e6_shifter_en", shifter_en, 0);
    ticks(1);
    check("gl_e7_shifter_en", shifter_en, 0);
    ticks(3);
    check("gl_e10_shifter_en", shifter_en, 0);
    check("gl_e10_data_out", data_out, CLAMP);
    tick();
    check("gl_e11_shifter_en", shifter_en, 1);
    check("gl_e11_data_out", data_out, 8'h5E);
    check("gl_fault_cnt", fault_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
